// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    FetchIdle,
    FetchReq,
    FetchWait,
    FetchHold,
    FetchDrop
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch between the PC stage and decode.
// Output registers double as the one-entry buffer presented to decode.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_pc_valid,
  input  logic [XLEN-1:0]  i_pc_data,
  input  logic             i_pc_update,
  input  logic             i_flush,
  output logic             o_imem_req_valid,
  input  logic             i_imem_req_ready,
  output logic [XLEN-1:0]  o_imem_req_addr,
  input  logic             i_imem_rsp_valid,
  input  logic [ILEN-1:0]  i_imem_rsp_data,
  output logic             o_inst_valid,
  input  logic             i_inst_ready,
  output logic [ILEN-1:0]  o_inst_data,
  output logic [XLEN-1:0]  o_inst_pc,
  output logic             o_inst_fault,
  output fetch_state_e     o_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, is held with stable payload until then.

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic             r_armed;
  logic             r_kill;
  logic [XLEN-1:0]  r_pc_q;
  logic             r_req_valid;
  logic             r_inst_valid;
  logic [ILEN-1:0]  r_inst_data;
  logic             r_inst_fault;

  logic             w_launch;
  logic             w_misaligned;
  logic             w_req_valid_nxt;
  logic             w_inst_valid_nxt;
  logic             w_capture;
  logic             w_fault_load;
  logic             w_kill_nxt;

  assign w_launch     = (r_state == FetchIdle) && i_pc_valid && r_armed && !i_flush;
  assign w_misaligned = is_misaligned(i_pc_data);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= FetchIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FetchIdle: if (w_launch) w_state_nxt = w_misaligned ? FetchHold : FetchReq;
      FetchReq:  if (i_imem_req_ready) w_state_nxt = (r_kill || i_flush) ? FetchDrop : FetchWait;
      FetchWait: begin
        if (i_imem_rsp_valid) w_state_nxt = i_flush ? FetchIdle : FetchHold;
        else if (i_flush)     w_state_nxt = FetchDrop;
      end
      FetchDrop: if (i_imem_rsp_valid) w_state_nxt = FetchIdle;
      FetchHold: if (i_flush || i_inst_ready) w_state_nxt = FetchIdle;
      default:   w_state_nxt = FetchIdle;
    endcase
  end

  always_comb begin
    w_req_valid_nxt  = (w_state_nxt == FetchReq);
    w_inst_valid_nxt = (w_state_nxt == FetchHold);
    w_capture        = (r_state == FetchWait) && i_imem_rsp_valid && !i_flush;
    w_fault_load     = w_launch && w_misaligned;
    w_kill_nxt       = r_kill;
    // A flush that cannot cancel the raised request marks its response for disposal.
    if ((r_state == FetchReq) && i_flush && !i_imem_req_ready) w_kill_nxt = 1'b1;
    else if ((r_state == FetchDrop) && i_imem_rsp_valid)       w_kill_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_armed      <= 1'b1;
      r_kill       <= 1'b0;
      r_pc_q       <= '0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      r_req_valid  <= w_req_valid_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_kill       <= w_kill_nxt;
      if (i_pc_update || i_flush) r_armed <= 1'b1;
      else if (w_launch)          r_armed <= 1'b0;
      if (w_launch) r_pc_q <= i_pc_data;
      if (w_fault_load) begin
        r_inst_data  <= '0;
        r_inst_fault <= 1'b1;
      end else if (w_capture) begin
        r_inst_data  <= i_imem_rsp_data;
        r_inst_fault <= 1'b0;
      end
    end
  end

  assign o_imem_req_valid = r_req_valid;
  assign o_imem_req_addr  = r_pc_q;
  assign o_inst_valid     = r_inst_valid;
  assign o_inst_data      = r_inst_data;
  assign o_inst_pc        = r_pc_q;
  assign o_inst_fault     = r_inst_fault;
  assign o_state          = r_state;

  a_rsp_in_window: assert property (@(posedge clk) disable iff (!rstn)
    i_imem_rsp_valid |-> (r_state == FetchWait || r_state == FetchDrop))
    else $error("instr_fetch: imem response with no outstanding request");

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter. It samples the current PC once per PC update, issues a single-outstanding read to instruction memory, and holds the returned instruction and its PC on a valid/ready interface toward decode. Misaligned PCs are flagged without a memory access, and a synchronous flush discards any in-flight or held fetch.

## Interface
- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- i_pc_valid  in  1  PC stage output is valid
- i_pc_data  in  XLEN  current PC
- i_pc_update  in  1  pulse; PC incr handshake completed this cycle, so the PC changes at this edge
- i_flush  in  1  pulse; discard current fetch (redirect)
- o_imem_req_valid  out  1  memory read request valid
- i_imem_req_ready  in  1  memory accepts request
- o_imem_req_addr  out  XLEN  word-aligned fetch address
- i_imem_rsp_valid  in  1  read data valid, exactly one per accepted request
- i_imem_rsp_data  in  ILEN  read data
- o_inst_valid  out  1  instruction available to decode
- i_inst_ready  in  1  decode accepts instruction
- o_inst_data  out  ILEN  instruction word (0 on fault)
- o_inst_pc  out  XLEN  PC of o_inst_data
- o_inst_fault  out  1  instruction-address-misaligned, qualified by o_inst_valid

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. Internal flags: armed, kill.
- Reset: state IDLE, armed=1, kill=0; all outputs 0.
- armed set on any edge where i_pc_update or i_flush is high; cleared when IDLE launches a fetch. Prevents refetching an unchanged PC.
- IDLE: if i_pc_valid & armed & !i_flush: latch pc_q=i_pc_data. If pc_q[1:0]!=0, go HOLD with fault=1, data=0, no memory access; else go REQ.
- REQ: o_imem_req_valid=1, o_imem_req_addr=pc_q. Request is never withdrawn once raised. On i_imem_req_ready: go WAIT, or DROP if kill is set or i_flush is high this cycle. i_flush in REQ without ready sets kill.
- WAIT: on i_imem_rsp_valid capture data, go HOLD (fault=0). If i_flush is high in the same cycle, go IDLE and discard data. If i_flush is high without a response, go DROP.
- DROP: wait for the single outstanding response, discard it, go IDLE, and clear kill.
- HOLD: o_inst_valid=1. Data, pc, and fault stay stable until accepted. On i_inst_ready go IDLE. i_flush has priority over ready: go IDLE, o_inst_valid=0 next cycle, no handshake counted.
- i_flush in IDLE only sets armed.
- i_imem_rsp_valid outside WAIT/DROP is a protocol error: flag it with $error and ignore the response.
- Address passes through unchanged. No PC arithmetic in this block.

## Timing
- All outputs are registered.
- Minimum PC-to-instruction latency with a zero-wait memory: IDLE sample at edge 0, request valid cycle 1 and accepted, WAIT cycle 2 with response, o_inst_valid in cycle 3.
- Memory response arrives no earlier than the cycle after request acceptance.
- Throughput is at most one instruction per 4 cycles (one outstanding request, no prefetch).
- The cycle after the HOLD handshake is IDLE. A new fetch launches only once armed is set by the PC update.
- Reset mid-operation: return immediately to the reset state. A response from a pre-reset request is the memory's responsibility to suppress.

## Structure
- riscvPkg: add fetch_state_e enum (FetchIdle, FetchReq, FetchWait, FetchHold, FetchDrop) and a localparam for the misaligned mask (2'b11).
- Single module, no sub-modules. The output register set acts as a one-entry holding buffer.

## Test plan
- Reset, PC=0x00000000 valid, memory ready=1, response next cycle with 0x00000013 -> o_inst_valid in cycle 3, data 0x00000013, pc 0x0, fault=0. No second request until i_pc_update.
- i_inst_ready held low 5 cycles in HOLD -> data/pc stable, no new request. Ready high -> one handshake, IDLE next cycle.
- PC=0x00000006 -> no memory request; o_inst_valid with fault=1, data=0, pc=0x6.
- i_imem_req_ready low 3 cycles with i_flush pulsed in the second -> request stays valid with constant address; after acceptance the response is dropped and o_inst_valid never rises.
- i_flush in the same cycle as the response in WAIT -> response discarded, IDLE. The next fetch uses the redirected PC (e.g. 0x00000100) after i_pc_update.
- rstn low during WAIT -> all outputs 0 the next cycle, state IDLE, armed=1. A fetch of PC=0 launches after rstn deasserts.
